// File: rtl/flash_rom_loader_pkg.sv
// rtl/flash_rom_loader_pkg.sv - state encodings and widths shared by the flash ROM loader
package flash_rom_loader_pkg;
  localparam int FLASH_AW        = 24;
  localparam int FLASH_DW        = 8;
  localparam int DEFAULT_TIMEOUT = 8;

  typedef enum logic [2:0] {
    R_IDLE,
    R_WREADY,
    R_ISSUE,
    R_WBUSY,
    R_WDONE,
    R_END
  } rd_state_e;

  typedef enum logic {
    W_IDLE,
    W_REQ
  } wr_state_e;
endpackage

// File: rtl/flash_rom_loader_byte_buf.sv
// rtl/flash_rom_loader_byte_buf.sv - one-entry holding register between flash reads and RAM writes
module loader_byte_buf
  import flash_rom_loader_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                capture,
  input  logic                drain,
  input  logic [FLASH_DW-1:0] din,
  output logic                full,
  output logic [FLASH_DW-1:0] dout
);
  logic                full_q, full_d;
  logic [FLASH_DW-1:0] data_q, data_d;

  // A capture in the same cycle as a drain keeps the entry full with the new byte.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush) begin
      full_d = 1'b0;
      data_d = '0;
    end else begin
      if (drain) full_d = 1'b0;
      if (capture) begin
        full_d = 1'b1;
        data_d = din;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign dout = data_q;
endmodule

// File: rtl/flash_rom_loader.sv
// rtl/flash_rom_loader.sv - boot-time copier from the DSPI flash reader into the RAM write port
module flash_rom_loader
  import flash_rom_loader_pkg::*;
#(
  parameter logic [FLASH_AW-1:0] FLASH_BASE = 24'h100000,
  parameter int                  MEM_AW     = 22,
  parameter logic [MEM_AW-1:0]   MEM_BASE   = '0,
  parameter int                  LENGTH     = 'h4000,
  parameter int                  TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  output logic                done,
  output logic                error,
  input  logic                flash_ready,
  input  logic                flash_busy,
  output logic [FLASH_AW-1:0] flash_addr,
  output logic                flash_cs,
  input  logic [FLASH_DW-1:0] flash_dout,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [FLASH_DW-1:0] mem_din,
  output logic                mem_we,
  input  logic                mem_ack
);
  localparam int CW = $clog2(LENGTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  rd_state_e           r_state_q, r_state_d;
  wr_state_e           w_state_q, w_state_d;
  logic                start_q, running_q, running_d;
  logic                done_q, done_d, error_q, error_d;
  logic                flash_cs_q, flash_cs_d, mem_we_q, mem_we_d;
  logic [FLASH_AW-1:0] flash_addr_q, flash_addr_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [CW-1:0]       rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                launch, drain, capture, timeout, buf_full;

  // A start edge is only honoured while no copy is in flight.
  assign launch = start & ~start_q & ~running_q;
  assign drain  = (w_state_q == W_REQ) & mem_ack;

  always_comb begin
    r_state_d    = r_state_q;
    w_state_d    = w_state_q;
    running_d    = running_q;
    done_d       = done_q;
    error_d      = error_q;
    mem_we_d     = mem_we_q;
    flash_addr_d = flash_addr_q;
    mem_addr_d   = mem_addr_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    tmr_d        = tmr_q;
    capture      = 1'b0;
    timeout      = 1'b0;

    case (r_state_q)
      R_WREADY: if (flash_ready && !flash_busy) r_state_d = R_ISSUE;
      R_ISSUE: begin
        r_state_d = R_WBUSY;
        tmr_d     = TW'(1);
      end
      R_WBUSY: begin
        if (flash_busy) r_state_d = R_WDONE;
        else if (tmr_q >= TW'(TIMEOUT - 1)) timeout = 1'b1;
        else tmr_d = tmr_q + TW'(1);
      end
      // flash_dout holds after busy falls, so a full buffer simply delays the capture.
      R_WDONE: begin
        if (!flash_busy && (!buf_full || drain)) begin
          capture      = 1'b1;
          flash_addr_d = flash_addr_q + FLASH_AW'(1);
          rd_cnt_d     = rd_cnt_q + CW'(1);
          r_state_d    = (rd_cnt_q == CW'(LENGTH - 1)) ? R_END : R_ISSUE;
        end
      end
      default: ;
    endcase

    case (w_state_q)
      W_IDLE: begin
        if (buf_full) begin
          w_state_d = W_REQ;
          mem_we_d  = 1'b1;
        end
      end
      W_REQ: begin
        if (mem_ack) begin
          w_state_d  = W_IDLE;
          mem_we_d   = 1'b0;
          mem_addr_d = mem_addr_q + MEM_AW'(1);
          wr_cnt_d   = wr_cnt_q + CW'(1);
          if (wr_cnt_q == CW'(LENGTH - 1)) begin
            done_d    = 1'b1;
            running_d = 1'b0;
          end
        end
      end
      default: ;
    endcase

    if (timeout) begin
      error_d   = 1'b1;
      running_d = 1'b0;
      r_state_d = R_IDLE;
      w_state_d = W_IDLE;
      mem_we_d  = 1'b0;
    end

    if (launch) begin
      done_d       = 1'b0;
      error_d      = 1'b0;
      running_d    = 1'b1;
      r_state_d    = R_WREADY;
      w_state_d    = W_IDLE;
      mem_we_d     = 1'b0;
      flash_addr_d = FLASH_BASE;
      mem_addr_d   = MEM_BASE;
      rd_cnt_d     = '0;
      wr_cnt_d     = '0;
    end

    flash_cs_d = (r_state_d == R_ISSUE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q    <= R_IDLE;
      w_state_q    <= W_IDLE;
      start_q      <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      flash_cs_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      flash_addr_q <= FLASH_BASE;
      mem_addr_q   <= MEM_BASE;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      tmr_q        <= '0;
    end else begin
      r_state_q    <= r_state_d;
      w_state_q    <= w_state_d;
      start_q      <= start;
      running_q    <= running_d;
      done_q       <= done_d;
      error_q      <= error_d;
      flash_cs_q   <= flash_cs_d;
      mem_we_q     <= mem_we_d;
      flash_addr_q <= flash_addr_d;
      mem_addr_q   <= mem_addr_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      tmr_q        <= tmr_d;
    end
  end

  loader_byte_buf u_buf (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (launch | timeout),
    .capture (capture),
    .drain   (drain),
    .din     (flash_dout),
    .full    (buf_full),
    .dout    (mem_din)
  );

  assign done       = done_q;
  assign error      = error_q;
  assign flash_cs   = flash_cs_q;
  assign flash_addr = flash_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
endmodule

// File: tb/tb_flash_rom_loader.sv
// tb/tb_flash_rom_loader.sv - directed bench for flash_rom_loader with flash and RAM models
module tb_flash_rom_loader;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       flash_ready = 1'b1;
  logic       init_busy = 1'b0;
  logic       no_busy = 1'b0;
  logic       mdl_clr = 1'b0;
  logic [1:0] start_v = 2'b00;
  int         ack_dly = 1;
  int         errors = 0;
  int         checks = 0;
  logic [7:0]  exp_b [4] = '{8'h5A, 8'h5B, 8'h58, 8'h59};
  logic [7:0]  exp_wb [4] = '{8'hA4, 8'hA5, 8'h5A, 8'h5B};
  logic [23:0] exp_wa [4] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};

  always #5 clk = ~clk;

  // Instance 0 copies from 0x100000, instance 1 exercises 24-bit address wrap.
  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam logic [23:0] BASE = (g == 0) ? 24'h100000 : 24'hFFFFFE;
    logic        done, error, flash_busy, flash_cs, mem_we, xfer_busy;
    logic        mem_ack = 1'b0;
    logic [23:0] flash_addr;
    logic [7:0]  flash_dout = 8'h00;
    logic [7:0]  mem_din;
    logic [21:0] mem_addr;
    int          cnt = 0, ack_cnt = 0, cs_n = 0, ack_n = 0, max_ahead = 0;
    logic [23:0] cs_log [8];
    logic [7:0]  wd_log [8];
    logic [21:0] wa_log [8];

    flash_rom_loader #(
      .FLASH_BASE (BASE),
      .MEM_AW     (22),
      .MEM_BASE   (22'h0),
      .LENGTH     (4),
      .TIMEOUT    (8)
    ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start_v[g]),
      .done        (done),
      .error       (error),
      .flash_ready (flash_ready),
      .flash_busy  (flash_busy),
      .flash_addr  (flash_addr),
      .flash_cs    (flash_cs),
      .flash_dout  (flash_dout),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din),
      .mem_we      (mem_we),
      .mem_ack     (mem_ack)
    );

    assign xfer_busy  = (cnt >= 2) && (cnt <= 21);
    assign flash_busy = xfer_busy | (init_busy & (g == 0));

    always @(posedge clk) begin
      if (flash_cs && !no_busy) begin
        cnt        <= 1;
        flash_dout <= flash_addr[7:0] ^ 8'h5A;
      end else if (cnt != 0) begin
        cnt <= (cnt == 21) ? 0 : cnt + 1;
      end

      mem_ack <= 1'b0;
      if (mem_we && !mem_ack) begin
        if (ack_cnt + 1 >= ack_dly) begin
          mem_ack <= 1'b1;
          ack_cnt <= 0;
        end else begin
          ack_cnt <= ack_cnt + 1;
        end
      end else if (!mem_we) begin
        ack_cnt <= 0;
      end

      if (mdl_clr) begin
        cs_n      <= 0;
        ack_n     <= 0;
        max_ahead <= 0;
      end else begin
        if (flash_cs) begin
          cs_log[cs_n[2:0]] <= flash_addr;
          cs_n              <= cs_n + 1;
        end
        if (mem_we && !mem_ack && (ack_cnt + 1 >= ack_dly)) begin
          wa_log[ack_n[2:0]] <= mem_addr;
          wd_log[ack_n[2:0]] <= mem_din;
          ack_n              <= ack_n + 1;
        end
        if (cs_n - ack_n > max_ahead) max_ahead <= cs_n - ack_n;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_model();
    mdl_clr = 1'b1;
    tick(1);
    mdl_clr = 1'b0;
  endtask

  task automatic pulse_start(input int g);
    start_v[g] = 1'b0;
    tick(1);
    start_v[g] = 1'b1;
    tick(2);
    start_v[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if ((g == 0) ? g_u[0].done : g_u[1].done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(3);
    checks++; if (g_u[0].done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", g_u[0].done); end
    checks++; if (g_u[0].error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", g_u[0].error); end
    checks++; if (g_u[0].flash_cs !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", g_u[0].flash_cs); end
    checks++; if (g_u[0].mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", g_u[0].mem_we); end
    checks++; if (g_u[0].mem_addr !== 22'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", g_u[0].mem_addr); end
    checks++; if (g_u[0].mem_din !== 8'h0) begin errors++; $display("FAIL reset_mem_din: got %h want 0", g_u[0].mem_din); end
    checks++; if (g_u[0].flash_addr !== 24'h100000) begin errors++; $display("FAIL reset_flash_addr: got %h want 100000", g_u[0].flash_addr); end
    checks++; if (g_u[1].flash_addr !== 24'hFFFFFE) begin errors++; $display("FAIL reset_flash_addr_wrap: got %h want fffffe", g_u[1].flash_addr); end
    resetn = 1'b1;
    tick(5);
    checks++; if (g_u[0].flash_cs !== 1'b0 || g_u[0].done !== 1'b0) begin errors++; $display("FAIL idle_no_start: cs=%b done=%b want 0 0", g_u[0].flash_cs, g_u[0].done); end
  endtask

  task automatic test_basic();
    bit ok;
    clear_model();
    ack_dly = 1;
    pulse_start(0);
    for (int i = 0; i < 100 && g_u[0].cs_n == 0; i++) tick(1);
    pulse_start(0);
    wait_done(0, 2000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", ok); end
    checks++; if (g_u[0].error !== 1'b0) begin errors++; $display("FAIL basic_error: got %b want 0", g_u[0].error); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (g_u[0].wd_log[i] !== exp_b[i] || g_u[0].wa_log[i] !== 22'(i)) begin
        errors++; $display("FAIL basic_write%0d: got %h@%h want %h@%h", i, g_u[0].wd_log[i], g_u[0].wa_log[i], exp_b[i], 22'(i));
      end
    end
    tick(30);
    checks++; if (g_u[0].cs_n !== 4) begin errors++; $display("FAIL basic_cs_count: got %0d want 4", g_u[0].cs_n); end
    checks++; if (g_u[0].ack_n !== 4) begin errors++; $display("FAIL basic_ack_count: got %0d want 4", g_u[0].ack_n); end
    checks++; if (g_u[0].mem_we !== 1'b0 || g_u[0].done !== 1'b1) begin errors++; $display("FAIL basic_hold: we=%b done=%b want 0 1", g_u[0].mem_we, g_u[0].done); end
  endtask

  task automatic test_slow_ram();
    bit ok;
    clear_model();
    ack_dly = 60;
    pulse_start(0);
    checks++; if (g_u[0].done !== 1'b0) begin errors++; $display("FAIL slow_done_cleared: got %b want 0", g_u[0].done); end
    wait_done(0, 3000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL slow_done: got %b want 1", ok); end
    checks++; if (g_u[0].ack_n !== 4 || g_u[0].cs_n !== 4) begin errors++; $display("FAIL slow_counts: acks=%0d cs=%0d want 4 4", g_u[0].ack_n, g_u[0].cs_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (g_u[0].wd_log[i] !== exp_b[i]) begin errors++; $display("FAIL slow_byte%0d: got %h want %h", i, g_u[0].wd_log[i], exp_b[i]); end
    end
    checks++; if (g_u[0].max_ahead > 2) begin errors++; $display("FAIL slow_ahead: got %0d want <=2", g_u[0].max_ahead); end
    ack_dly = 1;
  endtask

  task automatic test_init_gating();
    bit ok;
    clear_model();
    flash_ready = 1'b0;
    pulse_start(0);
    tick(100);
    checks++; if (g_u[0].cs_n !== 0) begin errors++; $display("FAIL gate_not_ready: cs=%0d want 0", g_u[0].cs_n); end
    flash_ready = 1'b1;
    init_busy = 1'b1;
    tick(28);
    checks++; if (g_u[0].cs_n !== 0) begin errors++; $display("FAIL gate_dummy_busy: cs=%0d want 0", g_u[0].cs_n); end
    init_busy = 1'b0;
    wait_done(0, 2000, ok);
    checks++; if (ok !== 1'b1 || g_u[0].cs_n !== 4) begin errors++; $display("FAIL gate_copy: done=%b cs=%0d want 1 4", ok, g_u[0].cs_n); end
    checks++; if (g_u[0].wd_log[3] !== 8'h59) begin errors++; $display("FAIL gate_last_byte: got %h want 59", g_u[0].wd_log[3]); end
  endtask

  task automatic test_timeout();
    bit found = 1'b0;
    clear_model();
    no_busy = 1'b1;
    start_v[0] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (g_u[0].flash_cs) begin found = 1'b1; break; end
    end
    start_v[0] = 1'b0;
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL timeout_cs_seen: got %b want 1", found); end
    tick(7);
    checks++; if (g_u[0].error !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0 at cs+7", g_u[0].error); end
    tick(1);
    checks++; if (g_u[0].error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1 at cs+8", g_u[0].error); end
    tick(10);
    checks++; if (g_u[0].done !== 1'b0 || g_u[0].mem_we !== 1'b0) begin errors++; $display("FAIL timeout_stop: done=%b we=%b want 0 0", g_u[0].done, g_u[0].mem_we); end
    checks++; if (g_u[0].cs_n !== 1 || g_u[0].error !== 1'b1) begin errors++; $display("FAIL timeout_sticky: cs=%0d err=%b want 1 1", g_u[0].cs_n, g_u[0].error); end
    no_busy = 1'b0;
  endtask

  task automatic test_restart_after_error();
    bit ok;
    clear_model();
    pulse_start(0);
    checks++; if (g_u[0].error !== 1'b0) begin errors++; $display("FAIL restart_error_cleared: got %b want 0", g_u[0].error); end
    wait_done(0, 2000, ok);
    checks++; if (ok !== 1'b1 || g_u[0].cs_n !== 4) begin errors++; $display("FAIL restart_copy: done=%b cs=%0d want 1 4", ok, g_u[0].cs_n); end
    checks++; if (g_u[0].wd_log[0] !== 8'h5A || g_u[0].cs_log[0] !== 24'h100000) begin errors++; $display("FAIL restart_first: got %h@%h want 5a@100000", g_u[0].wd_log[0], g_u[0].cs_log[0]); end
  endtask

  task automatic test_reset_mid_copy();
    bit ok;
    bit found = 1'b0;
    clear_model();
    ack_dly = 10;
    pulse_start(0);
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (g_u[0].mem_we && g_u[0].mem_addr == 22'd1) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_reach_byte2: got %b want 1", found); end
    tick(3);
    resetn = 1'b0;
    #1;
    checks++; if ({g_u[0].done, g_u[0].error, g_u[0].flash_cs, g_u[0].mem_we} !== 4'b0) begin errors++; $display("FAIL mid_reset_flags: got %b want 0000", {g_u[0].done, g_u[0].error, g_u[0].flash_cs, g_u[0].mem_we}); end
    checks++; if (g_u[0].mem_addr !== 22'h0 || g_u[0].flash_addr !== 24'h100000) begin errors++; $display("FAIL mid_reset_addr: got %h/%h want 0/100000", g_u[0].mem_addr, g_u[0].flash_addr); end
    tick(3);
    resetn = 1'b1;
    clear_model();
    ack_dly = 1;
    pulse_start(0);
    wait_done(0, 2000, ok);
    checks++; if (ok !== 1'b1 || g_u[0].ack_n !== 4) begin errors++; $display("FAIL mid_recopy: done=%b acks=%0d want 1 4", ok, g_u[0].ack_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (g_u[0].wd_log[i] !== exp_b[i] || g_u[0].wa_log[i] !== 22'(i)) begin
        errors++; $display("FAIL mid_byte%0d: got %h@%h want %h@%h", i, g_u[0].wd_log[i], g_u[0].wa_log[i], exp_b[i], 22'(i));
      end
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    clear_model();
    ack_dly = 1;
    pulse_start(1);
    wait_done(1, 2000, ok);
    checks++; if (ok !== 1'b1 || g_u[1].cs_n !== 4) begin errors++; $display("FAIL wrap_done: done=%b cs=%0d want 1 4", ok, g_u[1].cs_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (g_u[1].cs_log[i] !== exp_wa[i] || g_u[1].wd_log[i] !== exp_wb[i]) begin
        errors++; $display("FAIL wrap_byte%0d: got %h from %h want %h from %h", i, g_u[1].wd_log[i], g_u[1].cs_log[i], exp_wb[i], exp_wa[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slow_ram();
    test_init_gating();
    test_timeout();
    test_restart_after_error();
    test_reset_mid_copy();
    test_addr_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
